muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative RV32M multiply/divide sequencer for the execute stage. One
//   operation at a time: radix-2 shift-add multiply or restoring divide over
//   DATA_WIDTH iteration cycles on operand magnitudes, then one sign-fix cycle,
//   then a one-cycle DONE with the registered result. Divide-by-zero and the
//   signed-overflow divide finish straight from IDLE to DONE.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       valid M-op in execute; sampled only in IDLE
//   funct3      op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   flush       pipeline flush; aborts the operation in flight
//   operand_A   rs1 (multiplicand / dividend)
//   operand_B   rs2 (multiplier / divisor)
//   stall_MULT  hold request to the stall control unit
//   done        one-cycle pulse, result valid
//   result      registered result, held until the next done
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic                  stall_MULT,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]  cnt;
  logic [2:0]     op;
  logic           sign_a, sign_b;
  logic [W-1:0]   opnd;      // multiplicand (multiply) or divisor (divide)
  logic [2*W-1:0] acc;       // {partial/remainder, multiplier/quotient}

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + W'(1);
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + (2*W)'(1);
  endfunction

  // Operand decode while in IDLE
  logic         a_signed, b_signed, sa_in, sb_in;
  logic [W-1:0] abs_a, abs_b;
  logic         b_zero, div_ovf, fast;
  logic [W-1:0] fast_result;
  logic         accept;

  // MUL takes the unsigned path: the low word does not depend on signedness.
  assign a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                    (funct3 == 3'd4) || (funct3 == 3'd6);
  assign b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign sa_in    = a_signed & operand_A[W-1];
  assign sb_in    = b_signed & operand_B[W-1];
  assign abs_a    = sa_in ? neg_w(operand_A) : operand_A;
  assign abs_b    = sb_in ? neg_w(operand_B) : operand_B;

  assign b_zero   = (operand_B == '0);
  assign div_ovf  = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                    (operand_A == MIN_NEG) && (operand_B == '1);
  assign fast     = (funct3[2] && b_zero) || div_ovf;
  // funct3[1] separates remainder from quotient among the divide ops
  assign fast_result = b_zero ? (funct3[1] ? operand_A : '1)
                              : (funct3[1] ? '0 : MIN_NEG);

  assign accept   = (state == IDLE) && start && !flush;

  // One iteration of shift-add multiply
  logic [W:0]     mul_sum, mul_hi;
  logic [2*W-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
  assign mul_hi   = acc[0] ? mul_sum : {1'b0, acc[2*W-1:W]};
  assign mul_next = {mul_hi, acc[W-1:1]};

  // One iteration of restoring divide; diff[W] set means borrow (restore)
  logic [W:0]     div_shift, div_diff;
  logic [2*W-1:0] div_next;

  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

  // Sign fix and word select
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, fix_result;

  assign prod = (sign_a ^ sign_b) ? neg_2w(acc) : acc;
  assign quo  = (sign_a ^ sign_b) ? neg_w(acc[W-1:0]) : acc[W-1:0];
  assign rem  = sign_a ? neg_w(acc[2*W-1:W]) : acc[2*W-1:W];
  assign fix_result = op[2] ? (op[1] ? rem : quo)
                            : ((op == 3'd0) ? prod[W-1:0] : prod[2*W-1:W]);

  logic         load_result;
  logic [W-1:0] result_next;

  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    result_next = result;
    stall_MULT  = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        stall_MULT = start & ~flush & ~reset;
        if (start) begin
          if (fast) begin
            state_next  = DONE;
            load_result = 1'b1;
            result_next = fast_result;
          end else begin
            state_next  = RUN;
          end
        end
      end
      RUN: begin
        stall_MULT = 1'b1;
        if (cnt == '0) state_next = FIX;
      end
      FIX: begin
        stall_MULT  = 1'b1;
        state_next  = DONE;
        load_result = 1'b1;
        result_next = fix_result;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flush aborts from any state without touching result or pulsing done
    if (flush) begin
      state_next  = IDLE;
      load_result = 1'b0;
      done        = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= CW'(W - 1);
      else if ((state == RUN) && (cnt != '0))
        cnt <= cnt - CW'(1);
      if (load_result)
        result <= result_next;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clock) begin
    if (accept) begin
      op     <= funct3;
      sign_a <= sa_in;
      sign_b <= sb_in;
      if (funct3[2]) begin
        opnd <= abs_b;
        acc  <= {{W{1'b0}}, abs_a};
      end else begin
        opnd <= abs_a;
        acc  <= {{W{1'b0}}, abs_b};
      end
    end else if (state == RUN) begin
      acc <= op[2] ? div_next : mul_next;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Directed and randomized bench for muldiv_sequencer (DATA_WIDTH = 32).
//   Expected results come from a 64-bit arithmetic model of the RV32M rules;
//   latency and stall/done timing are checked cycle by cycle.
module tb_muldiv_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic        flush;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        stall_MULT;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .flush      (flush),
    .operand_A  (operand_A),
    .operand_B  (operand_B),
    .stall_MULT (stall_MULT),
    .done       (done),
    .result     (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && b == 32'd0) ||
           ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issues one op with start in "cycle 0" and checks stall/done every cycle
  // up to DONE, the result at DONE, and that the result holds afterwards.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int lat;
    lat = is_fast(f, a, b) ? 1 : 34;
    step();
    start = 1'b1; funct3 = f; operand_A = a; operand_B = b;
    @(negedge clock);
    check({tag, " ctl c0"}, {30'b0, stall_MULT, done}, 32'd2);
    for (int c = 1; c <= lat; c++) begin
      step();
      // start and operands are don't-care once the op is accepted
      start     = 1'($urandom_range(0, 1));
      funct3    = 3'($urandom);
      operand_A = $urandom;
      operand_B = $urandom;
      @(negedge clock);
      check($sformatf("%s ctl c%0d", tag, c), {30'b0, stall_MULT, done},
            {30'b0, (c < lat), (c == lat)});
      if (c == lat) check({tag, " result"}, result, exp);
    end
    step();
    start = 1'b0;
    @(negedge clock);
    check({tag, " hold"}, {31'b0, done}, 32'd0);
    check({tag, " hold result"}, result, exp);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b, prev;
    int          mode;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; operand_A = 32'd0; operand_B = 32'd0;
    step(); step();
    @(negedge clock);
    check("reset result", result, 32'd0);
    check("reset ctl", {30'b0, stall_MULT, done}, 32'd0);
    start = 1'b1;
    #1;
    check("reset start stall", {31'b0, stall_MULT}, 32'd0);
    step();
    reset = 1'b0; start = 1'b0;

    // Directed cases
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, "mul");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem");
    run_op(3'd5, 32'd100,       32'd7,         32'd14,        "divu");
    run_op(3'd7, 32'd100,       32'd7,         32'd2,         "remu");
    run_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu0");
    run_op(3'd6, 32'd5,         32'd0,         32'd5,         "rem0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "removf");

    // Flush in cycle 10 of a DIV; new MUL starts in cycle 12
    prev = result;
    step();
    start = 1'b1; funct3 = 3'd4; operand_A = 32'd1000; operand_B = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = 1'b0;
      if (c == 10) flush = 1'b1;
      @(negedge clock);
      check($sformatf("flush ctl c%0d", c), {30'b0, stall_MULT, done}, 32'd2);
    end
    step();
    flush = 1'b0;
    @(negedge clock);
    check("flush idle ctl", {30'b0, stall_MULT, done}, 32'd0);
    check("flush result", result, prev);
    run_op(3'd0, 32'd123, 32'd456, 32'd56088, "mul after flush");

    // Reset in cycle 20 of a MUL, start held with reset
    step();
    start = 1'b1; funct3 = 3'd0; operand_A = 32'd9; operand_B = 32'd9;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
      if (c == 20) begin reset = 1'b1; start = 1'b1; end
    end
    step();
    @(negedge clock);
    check("rst mid result", result, 32'd0);
    check("rst mid ctl", {30'b0, stall_MULT, done}, 32'd0);
    step();
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    check("rst idle ctl", {30'b0, stall_MULT, done}, 32'd0);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      f    = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin
        a = $urandom_range(0, 200);
        b = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      run_op(f, a, b, ref_model(f, a, b), $sformatf("rand%0d f%0d", i, f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
